// File: rtl/input_cond_pkg.sv
// ---------------------------------------------------------------------------
// input_cond_pkg
//
// Shared constants and helpers for the input conditioner front end that sits
// ahead of the lab sequence-detector FSM.
//
// Contents:
//   DEBOUNCE_CYCLES_DEF : default debounce length (10 ms at 100 MHz)
//   REPEAT_CYCLES_DEF   : default auto-repeat period (250 ms at 100 MHz)
//   cnt_width()         : counter width for a counter that must reach n-1
// ---------------------------------------------------------------------------
package input_cond_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int REPEAT_CYCLES_DEF   = 25000000;

  // A counter that runs 0..n-1 needs $clog2(n) bits. Never return zero so
  // that a degenerate n still yields a legal vector width.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
//
// One-bit conditioning channel: a 2-flop synchroniser brings the raw,
// asynchronous input into clk, then a counter requires the synchronised
// level to differ from the held value for DEBOUNCE_CYCLES consecutive
// cycles before the held value follows it.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept a change
//                     (minimum 2)
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high; clears synchroniser, db and count
//   raw   : raw asynchronous, bouncy input
//   db    : debounced, stable level
// ---------------------------------------------------------------------------
module debounce_sync
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser. s1 may go metastable; only s2 is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce counter. Any cycle where s2 agrees with the held value restarts
  // the count, so a single-cycle bounce back to the old level costs the full
  // debounce time again. The held value flips on the cycle the count has
  // already seen DEBOUNCE_CYCLES-1 differing cycles and s2 still differs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Front end for the lab sequence-detector FSM. The raw slide switch becomes a
// clean level w, and the raw push-button becomes a one-cycle step strobe the
// FSM uses as its clock enable.
//
// Build option:
//   INPUT_COND_AUTOREPEAT_EN : when defined, holding the button produces an
//                              extra step every REPEAT_CYCLES cycles after
//                              the press strobe. Undefined: one step per press.
//
// Parameters:
//   DEBOUNCE_CYCLES : debounce length in clk cycles (minimum 2)
//   REPEAT_CYCLES   : auto-repeat period (only used with auto-repeat built in)
// Ports:
//   clk     : sole clock, rising edge
//   reset   : asynchronous, active-high; clears all state
//   sw_raw  : raw switch level, asynchronous and bouncy
//   btn_raw : raw step button, asynchronous and bouncy, high = pressed
//   w       : debounced switch level, feeds FSM input w
//   step    : one-cycle strobe per accepted press (plus repeats if enabled)
//   leds    : {btn_db, w} for board debug
// ---------------------------------------------------------------------------
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_raw,
  input  logic       btn_raw,
  output logic       w,
  output logic       step,
  output logic [1:0] leds
);

  logic sw_db;
  logic btn_db;
  logic btn_prev;
  logic press_edge;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_chan (
    .clk  (clk),
    .reset(reset),
    .raw  (sw_raw),
    .db   (sw_db)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_chan (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_raw),
    .db   (btn_db)
  );

  // Delayed copy of the debounced button for rising-edge detection. Since
  // both btn_db and btn_prev are registers, the strobe is glitch-free and a
  // release (1 -> 0) can never produce it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_db;
    end
  end

  assign press_edge = btn_db & ~btn_prev;

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int            RW      = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_fire;

  // Repeat counter. It is parked at zero while the button is released and is
  // re-zeroed on the press strobe itself, so the first repeat lands exactly
  // REPEAT_CYCLES cycles after the press strobe and then every period after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (!btn_db || press_edge) begin
      rep_cnt <= '0;
    end else if (rep_cnt == REP_MAX) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign rep_fire = btn_db & (rep_cnt == REP_MAX);
  assign step     = press_edge | rep_fire;
`else
  assign step = press_edge;
`endif

  assign w    = sw_db;
  assign leds = {btn_db, sw_db};

endmodule
